cdn_usb4_os_stats_monitor: RTL and testbench

Synthesisable, parametrised ordered-set statistics block for the USB4 link layer. It counts TX and RX ordered sets (TS1, TS2, SLOS1, SLOS2) per lane with saturating counters and tracks consecutive identical RX ordered sets to flag per-lane training lock. Counters are read through a registered single-cycle read port. It sits beside the logical-layer ordered-set encoder/decoder and feeds debug/CSR logic.

---
 rtl/cdn_usb4_os_stats_pkg.sv | 19 +
 rtl/cdn_usb4_sat_counter.sv | 43 ++++
 rtl/cdn_usb4_os_stats_monitor.sv | 152 +++++++++++++++
 tb/tb_cdn_usb4_os_stats_monitor.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cdn_usb4_os_stats_pkg.sv
// Shared types and constants for the USB4 ordered-set statistics block.
// No logic; type and constant definitions only.
// No flow control; consumers import these definitions directly.
package cdn_usb4_os_stats_pkg;

    typedef enum logic [1:0] {
        OS_TS1   = 2'd0,
        OS_TS2   = 2'd1,
        OS_SLOS1 = 2'd2,
        OS_SLOS2 = 2'd3
    } os_type_e;

    localparam int NUM_OS_TYPES = 4;

    // Direction selector, also the middle bit of a counter index
    localparam logic DIR_TX = 1'b0;
    localparam logic DIR_RX = 1'b1;

endpackage

// File: rtl/cdn_usb4_sat_counter.sv
// Saturating event counter with clear and hold controls.
// Latency: an increment is visible on count one cycle after inc.
// No backpressure: clear beats hold, hold beats increment, all-ones never wraps.
module cdn_usb4_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    input  logic             hold,
    output logic [WIDTH-1:0] count,
    output logic             sat
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign count = count_q;
    assign sat   = &count_q;

    // Next-state: clear has top priority, then hold, then a non-wrapping increment
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (hold) begin
            count_d = count_q;
        end else if (inc && !sat) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cdn_usb4_os_stats_monitor.sv
// Per-lane TX/RX ordered-set counters plus RX run tracking for training lock.
// Latency: counts readable 1 cycle after the strobe, rd_data 1 cycle after rd_en, lock 2 cycles.
// No backpressure: every strobe is accepted, one read result per cycle.
module cdn_usb4_os_stats_monitor
    import cdn_usb4_os_stats_pkg::*;
#(
    parameter int NUM_LANES    = 2,
    parameter int CNT_WIDTH    = 16,
    parameter int CONSEC_WIDTH = 5,
    parameter int LOCK_THRESH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_LANES-1:0]   tx_os_valid,
    input  logic [2*NUM_LANES-1:0] tx_os_type,
    input  logic [NUM_LANES-1:0]   rx_os_valid,
    input  logic [2*NUM_LANES-1:0] rx_os_type,
    input  logic [NUM_LANES-1:0]   rx_os_err,
    input  logic                   cnt_clear,
    input  logic                   cnt_freeze,
    input  logic                   rd_en,
    input  logic [1:0]             rd_lane,
    input  logic                   rd_dir,
    input  logic [1:0]             rd_type,
    output logic                   rd_valid,
    output logic [CNT_WIDTH-1:0]   rd_data,
    output logic [NUM_LANES-1:0]   rx_lock,
    output logic [2*NUM_LANES-1:0] rx_lock_type,
    output logic                   any_sat
);

    // Counter index is {lane, dir, type}; 32 slots cover the full rd_lane range
    localparam int NUM_CNT  = NUM_LANES * 2 * NUM_OS_TYPES;
    localparam int RD_SLOTS = 32;
    localparam logic [CONSEC_WIDTH-1:0] CONSEC_MAX = {CONSEC_WIDTH{1'b1}};
    localparam logic [CONSEC_WIDTH-1:0] LOCK_LVL   = CONSEC_WIDTH'(LOCK_THRESH);

    logic [CNT_WIDTH-1:0] cnt_w [NUM_CNT];
    logic [NUM_CNT-1:0]   sat_w;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        for (genvar d = 0; d < 2; d++) begin : g_dir
            for (genvar t = 0; t < NUM_OS_TYPES; t++) begin : g_type
                localparam int IDX = l * 8 + d * 4 + t;
                logic inc_w;

                if (d == int'(DIR_TX)) begin : g_tx
                    assign inc_w = tx_os_valid[l] && (tx_os_type[2*l +: 2] == 2'(t));
                end else begin : g_rx
                    assign inc_w = rx_os_valid[l] && (rx_os_type[2*l +: 2] == 2'(t));
                end

                cdn_usb4_sat_counter #(
                    .WIDTH (CNT_WIDTH)
                ) u_cnt (
                    .clk   (clk),
                    .rst   (rst),
                    .inc   (inc_w),
                    .clr   (cnt_clear),
                    .hold  (cnt_freeze),
                    .count (cnt_w[IDX]),
                    .sat   (sat_w[IDX])
                );
            end
        end

        // RX run tracker: length of the current run of identical ordered sets
        os_type_e              last_type_q, last_type_d;
        logic [CONSEC_WIDTH-1:0] consec_q, consec_d;
        logic                    lock_q;
        os_type_e                lock_type_q;
        os_type_e                rx_type_w;

        assign rx_type_w = os_type_e'(rx_os_type[2*l +: 2]);

        // Run update: an error empties the run, a differing type restarts it at 1
        always_comb begin
            last_type_d = last_type_q;
            consec_d    = consec_q;
            if (rx_os_err[l]) begin
                consec_d = '0;
            end else if (rx_os_valid[l]) begin
                if ((rx_type_w == last_type_q) && (consec_q != '0)) begin
                    if (consec_q != CONSEC_MAX) begin
                        consec_d = consec_q + 1'b1;
                    end
                end else begin
                    last_type_d = rx_type_w;
                    consec_d    = CONSEC_WIDTH'(1);
                end
            end
        end

        // Run state and the registered lock view derived from it
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                last_type_q <= OS_TS1;
                consec_q    <= '0;
                lock_q      <= 1'b0;
                lock_type_q <= OS_TS1;
            end else begin
                last_type_q <= last_type_d;
                consec_q    <= consec_d;
                lock_q      <= (consec_q >= LOCK_LVL);
                lock_type_q <= last_type_q;
            end
        end

        assign rx_lock[l]             = lock_q;
        assign rx_lock_type[2*l +: 2] = lock_type_q;
    end

    // Read mux over a zero-padded slot array so out-of-range lanes read 0
    logic [CNT_WIDTH-1:0] rd_mux_w [RD_SLOTS];
    logic [4:0]           rd_idx_w;

    assign rd_idx_w = {rd_lane, rd_dir, rd_type};

    // Populate the implemented slots; the rest stay zero
    always_comb begin
        for (int i = 0; i < RD_SLOTS; i++) begin
            rd_mux_w[i] = '0;
        end
        for (int i = 0; i < NUM_CNT; i++) begin
            rd_mux_w[i] = cnt_w[i];
        end
    end

    logic                 rd_valid_q;
    logic [CNT_WIDTH-1:0] rd_data_q;
    logic                 any_sat_q;

    // Registered read port and saturation summary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            any_sat_q  <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_data_q <= rd_mux_w[rd_idx_w];
            end
            any_sat_q <= |sat_w;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign any_sat  = any_sat_q;

endmodule

// File: tb/tb_cdn_usb4_os_stats_monitor.sv
// Directed bench for the ordered-set statistics block with a read scoreboard.
// Reads push the modelled count when issued; a monitor pops on each rd_valid.
// Lock, saturation flag and reset behaviour are checked against fixed expectations.
module tb_cdn_usb4_os_stats_monitor;
    import cdn_usb4_os_stats_pkg::*;

    localparam int NL   = 2;
    localparam int CW   = 4;
    localparam int MAXC = 15;

    logic            clk = 1'b0;
    logic            rst;
    logic [NL-1:0]   tx_os_valid, rx_os_valid, rx_os_err, rx_lock;
    logic [2*NL-1:0] tx_os_type, rx_os_type, rx_lock_type;
    logic            cnt_clear, cnt_freeze, rd_en, rd_dir, rd_valid, any_sat;
    logic [1:0]      rd_lane, rd_type;
    logic [CW-1:0]   rd_data;

    int n_checks = 0;
    int n_fail   = 0;
    int mdl [NL][2][4];
    int rq [$];

    always #5 clk = ~clk;

    cdn_usb4_os_stats_monitor #(
        .NUM_LANES    (NL),
        .CNT_WIDTH    (CW),
        .CONSEC_WIDTH (5),
        .LOCK_THRESH  (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_os_valid  (tx_os_valid),
        .tx_os_type   (tx_os_type),
        .rx_os_valid  (rx_os_valid),
        .rx_os_type   (rx_os_type),
        .rx_os_err    (rx_os_err),
        .cnt_clear    (cnt_clear),
        .cnt_freeze   (cnt_freeze),
        .rd_en        (rd_en),
        .rd_lane      (rd_lane),
        .rd_dir       (rd_dir),
        .rd_type      (rd_type),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rx_lock      (rx_lock),
        .rx_lock_type (rx_lock_type),
        .any_sat      (any_sat)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        tx_os_valid = '0; tx_os_type = '0;
        rx_os_valid = '0; rx_os_type = '0; rx_os_err = '0;
        cnt_clear = 1'b0; cnt_freeze = 1'b0;
        rd_en = 1'b0; rd_lane = '0; rd_dir = 1'b0; rd_type = '0;
    endtask

    task automatic model_reset();
        for (int l = 0; l < NL; l++)
            for (int d = 0; d < 2; d++)
                for (int t = 0; t < 4; t++) mdl[l][d][t] = 0;
    endtask

    // One clock: queue the expected read, advance the model, then return idle inputs
    task automatic tick(input bit keep_freeze = 1'b0);
        int  lane;
        bit  inc;
        if (rd_en) begin
            lane = int'(rd_lane);
            if (lane < NL) rq.push_back(mdl[lane][rd_dir][rd_type]);
            else           rq.push_back(0);
        end
        for (int l = 0; l < NL; l++)
            for (int d = 0; d < 2; d++)
                for (int t = 0; t < 4; t++) begin
                    if (d == 0) inc = tx_os_valid[l] && (int'(tx_os_type[2*l +: 2]) == t);
                    else        inc = rx_os_valid[l] && (int'(rx_os_type[2*l +: 2]) == t);
                    if (cnt_clear)                          mdl[l][d][t] = 0;
                    else if (!cnt_freeze && inc && mdl[l][d][t] < MAXC) mdl[l][d][t]++;
                end
        @(posedge clk);
        #1;
        idle_inputs();
        cnt_freeze = keep_freeze;
    endtask

    task automatic rd(input int lane, input logic dir, input int typ);
        rd_en = 1'b1; rd_lane = 2'(lane); rd_dir = dir; rd_type = 2'(typ);
        tick();
    endtask

    task automatic rx(input int lane, input int typ, input bit err = 1'b0, input bit frz = 1'b0);
        rx_os_valid[lane]      = 1'b1;
        rx_os_type[2*lane +: 2] = 2'(typ);
        rx_os_err[lane]        = err;
        cnt_freeze             = frz;
        tick(frz);
    endtask

    // Scoreboard consumer: every rd_valid pulse must match the oldest queued read
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rd_valid === 1'b1) begin
                if (rq.size() == 0) check("rd_valid_spurious", rd_valid, 0);
                else                check("rd_data", rd_data, rq.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        model_reset();
        rst = 1'b1;
        #2;
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_rx_lock", rx_lock, 0);
        check("rst_rx_lock_type", rx_lock_type, 0);
        check("rst_any_sat", any_sat, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Saturation on lane 0 TX TS1, then clear
        for (int i = 0; i < 20; i++) begin
            tx_os_valid = 2'b01; tx_os_type = {2'(OS_TS1), 2'(OS_TS1)};
            tick();
        end
        rd(0, DIR_TX, OS_TS1);
        tick();
        check("sat_any_sat", any_sat, 1);
        cnt_clear = 1'b1;
        tick();
        tick();
        check("clr_any_sat", any_sat, 0);
        rd(0, DIR_TX, OS_TS1);

        // Clear wins over a same-cycle increment; a same-cycle read sees pre-clear value
        rx(1, OS_SLOS2);
        rx(1, OS_SLOS2);
        rx_os_valid = 2'b10; rx_os_type = {2'(OS_SLOS2), 2'(OS_TS1)};
        cnt_clear = 1'b1;
        rd_en = 1'b1; rd_lane = 2'd1; rd_dir = DIR_RX; rd_type = 2'(OS_SLOS2);
        tick();
        rd(1, DIR_RX, OS_SLOS2);

        // Freeze holds counters, release resumes counting
        for (int i = 0; i < 5; i++) rx(0, OS_TS2, 1'b0, 1'b1);
        rd(0, DIR_RX, OS_TS2);
        for (int i = 0; i < 3; i++) rx(0, OS_TS2);
        rd(0, DIR_RX, OS_TS2);

        // Lane 1 locks on TS1 after 16 strobes with idle gaps
        for (int i = 0; i < 16; i++) begin
            rx(1, OS_TS1);
            tick();
            if (i == 14) check("lock1_early", rx_lock[1], 0);
        end
        check("lock1_set", rx_lock[1], 1);
        check("lock1_type", rx_lock_type[3:2], 2'(OS_TS1));
        rx(1, OS_TS2);
        check("lock1_hold_1cyc", rx_lock[1], 1);
        tick();
        check("lock1_drop", rx_lock[1], 0);
        check("lock1_newtype", rx_lock_type[3:2], 2'(OS_TS2));

        // Lane 0 has 8 TS2 so far; 8 more lock it, then an error breaks the run
        for (int i = 0; i < 8; i++) rx(0, OS_TS2);
        tick();
        check("lock0_set", rx_lock[0], 1);
        check("lock0_type", rx_lock_type[1:0], 2'(OS_TS2));
        rx(0, OS_TS2, 1'b1);
        check("err_hold_1cyc", rx_lock[0], 1);
        tick();
        check("err_drop", rx_lock[0], 0);
        for (int i = 0; i < 15; i++) rx(0, OS_TS2);
        tick();
        check("err_no_relock15", rx_lock[0], 0);
        rx(0, OS_TS2);
        tick();
        check("err_relock16", rx_lock[0], 1);

        // Back-to-back reads plus an out-of-range lane
        rd(0, DIR_RX, OS_TS2);
        rd(1, DIR_RX, OS_TS1);
        rd(1, DIR_RX, OS_SLOS2);
        rd(3, DIR_RX, OS_TS1);
        tick();
        check("rd_valid_idle", rd_valid, 0);
        check("any_sat_again", any_sat, 1);

        // Asynchronous reset mid-run with live outputs
        rd(1, DIR_RX, OS_TS1);
        check("pre_rst_rd_valid", rd_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_rd_valid", rd_valid, 0);
        check("arst_rd_data", rd_data, 0);
        check("arst_rx_lock", rx_lock, 0);
        check("arst_rx_lock_type", rx_lock_type, 0);
        check("arst_any_sat", any_sat, 0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;

        // Run restarts at 1 after reset: 15 back-to-back TS1 do not lock, 16 do
        for (int i = 0; i < 15; i++) rx(0, OS_TS1);
        tick();
        check("post_rst_no_lock", rx_lock[0], 0);
        rx(0, OS_TS1);
        tick();
        check("post_rst_lock", rx_lock[0], 1);
        rd(0, DIR_RX, OS_TS1);
        repeat (3) tick();
        check("rd_queue_drained", rq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
